// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: opcodes, opcode
// classification helpers and the controller state encoding.
package alu_ctrl_pkg;

  localparam int OP_W   = 6;
  localparam int DATA_W = 32;

  localparam logic [OP_W-1:0] OP_ADD = 6'b010000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b010001;
  localparam logic [OP_W-1:0] OP_EQ  = 6'b100000;
  localparam logic [OP_W-1:0] OP_NE  = 6'b100001;
  localparam logic [OP_W-1:0] OP_LE  = 6'b100010;
  localparam logic [OP_W-1:0] OP_GT  = 6'b100011;
  localparam logic [OP_W-1:0] OP_SHL = 6'b110000;
  localparam logic [OP_W-1:0] OP_SHR = 6'b110001;
  localparam logic [OP_W-1:0] OP_SRA = 6'b110010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for every opcode the ALU understands.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB,
      OP_EQ, OP_NE, OP_LE, OP_GT,
      OP_SHL, OP_SHR, OP_SRA: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // True for the opcodes whose ans2 output is a carry/borrow worth keeping.
  function automatic logic is_addsub(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts one past the
// previous winner and wraps, so the previous winner has lowest priority.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;

  // Walk candidates in priority order last+1, last+2, ... and take the first requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(last) + off) % N))) begin
          gnt[i]  = 1'b1;
          gnt_idx = IW'(i);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external combinational ALU between N_REQ requesters.
// One command is in flight at a time; ALU inputs are registered at accept,
// results are captured one cycle later and held until the owner consumes them.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | arbitrate; req_ready to the winner, accept on handshake
// ST_EXEC | ALU inputs stable; result/flags captured at end of cycle
// ST_RESP | rsp_valid[owner] held until rsp_ready[owner]
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [6*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_use_c,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_carry,
  output logic                  rsp_z,
  output logic                  rsp_n,
  output logic                  rsp_err,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [5:0]            alu_op,
  output logic                  alu_c,
  input  logic [31:0]           alu_ans1,
  input  logic                  alu_ans2,
  input  logic                  alu_z,
  input  logic                  alu_n
);

  localparam int IW = $clog2(N_REQ);

  state_t state, state_nxt;

  logic [IW-1:0]    last;
  logic [IW-1:0]    owner;
  logic [N_REQ-1:0] cf;
  logic             pend_err;
  logic             pend_addsub;
  logic             accept;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;

  logic [5:0]       sel_op;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             sel_use_c;
  logic             sel_cf;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .last    (last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Route the winning requester's command fields and its stored carry.
  always_comb begin
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_use_c = 1'b0;
    sel_cf    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_op    = req_op[i*6 +: 6];
        sel_a     = req_a[i*32 +: 32];
        sel_b     = req_b[i*32 +: 32];
        sel_use_c = req_use_c[i];
        sel_cf    = cf[i];
      end
    end
  end

  // Next state plus the combinational handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = gnt;
        if (|req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (owner == IW'(i)) rsp_valid[i] = 1'b1;
        end
        if (rsp_ready[owner]) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // On accept: advance the round-robin pointer, remember the owner and
  // drive the ALU. Illegal opcodes leave the ALU inputs untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      last        <= IW'(N_REQ - 1);
      owner       <= '0;
      pend_err    <= 1'b0;
      pend_addsub <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_c       <= 1'b0;
    end else if (accept) begin
      last        <= gnt_idx;
      owner       <= gnt_idx;
      pend_err    <= !is_legal_op(sel_op);
      pend_addsub <= is_addsub(sel_op);
      if (is_legal_op(sel_op)) begin
        alu_a  <= sel_a;
        alu_b  <= sel_b;
        alu_op <= sel_op;
        alu_c  <= sel_use_c & sel_cf;
      end
    end
  end

  // Capture the ALU result at the end of EXEC and update the owner's carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_z     <= 1'b0;
      rsp_n     <= 1'b0;
      rsp_err   <= 1'b0;
      cf        <= '0;
    end else if (state == ST_EXEC) begin
      if (pend_err) begin
        rsp_data  <= '0;
        rsp_err   <= 1'b1;
        rsp_z     <= 1'b0;
        rsp_n     <= 1'b0;
        rsp_carry <= cf[owner];
      end else begin
        rsp_data <= alu_ans1;
        rsp_err  <= 1'b0;
        rsp_z    <= alu_z;
        rsp_n    <= alu_n;
        if (pend_addsub) begin
          cf[owner] <= alu_ans2;
          rsp_carry <= alu_ans2;
        end else begin
          rsp_carry <= cf[owner];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus a random phase, with a
// behavioural ALU beside the DUT and a scoreboard fed at command accept.
module tb_alu_req_arbiter;

  localparam int N = 2;

  localparam logic [5:0] T_ADD = 6'b010000;
  localparam logic [5:0] T_SUB = 6'b010001;
  localparam logic [5:0] T_SHL = 6'b110000;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, req_use_c, rsp_valid, rsp_ready;
  logic [6*N-1:0]   req_op;
  logic [32*N-1:0]  req_a, req_b;
  logic [31:0]      rsp_data;
  logic             rsp_carry, rsp_z, rsp_n, rsp_err;
  logic [31:0]      alu_a, alu_b, alu_ans1;
  logic [5:0]       alu_op;
  logic             alu_c, alu_ans2, alu_z, alu_n;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          who;
    logic [31:0] data;
    logic        carry;
    logic        z;
    logic        n;
    logic        err;
    int          acc;
  } exp_t;

  exp_t         q[$];
  logic [N-1:0] m_cf;
  int           m_last;
  bit           busy;
  bit           started;

  alu_req_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_use_c (req_use_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_z     (rsp_z),
    .rsp_n     (rsp_n),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .alu_ans1  (alu_ans1),
    .alu_ans2  (alu_ans2),
    .alu_z     (alu_z),
    .alu_n     (alu_n)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural ALU: {carry/borrow, result}.
  function automatic logic [32:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic c);
    logic [32:0] r;
    r = '0;
    case (op)
      6'b010000: r = {1'b0, a} + {1'b0, b} + {32'd0, c};
      6'b010001: r = {1'b0, a} - {1'b0, b} - {32'd0, c};
      6'b100000: r = {32'd0, (a == b)};
      6'b100001: r = {32'd0, (a != b)};
      6'b100010: r = {32'd0, ($signed(a) <= $signed(b))};
      6'b100011: r = {32'd0, ($signed(a) > $signed(b))};
      6'b110000: r = {1'b0, a << b[4:0]};
      6'b110001: r = {1'b0, a >> b[4:0]};
      6'b110010: r = {1'b0, 32'($signed(a) >>> b[4:0])};
      default:   r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    {alu_ans2, alu_ans1} = alu_fn(alu_op, alu_a, alu_b, alu_c);
    alu_z = (alu_ans1 == 32'd0);
    alu_n = alu_ans1[31];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Round-robin choice from the rule: first valid requester after the last winner.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
    logic [N-1:0] r;
    int i;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      i = (last + k) % N;
      if (v[i] && r == '0) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Expected response for a command, updating the model carry flags.
  function automatic exp_t predict(input int who, input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic uc);
    exp_t e;
    logic [32:0] r;
    e.who = who;
    e.acc = cyc;
    if (!(op inside {6'b010000, 6'b010001, 6'b100000, 6'b100001, 6'b100010,
                     6'b100011, 6'b110000, 6'b110001, 6'b110010})) begin
      e.data = '0; e.err = 1'b1; e.z = 1'b0; e.n = 1'b0; e.carry = m_cf[who];
    end else begin
      r = alu_fn(op, a, b, uc ? m_cf[who] : 1'b0);
      e.data = r[31:0];
      e.err  = 1'b0;
      e.z    = (r[31:0] == 32'd0);
      e.n    = r[31];
      if (op == 6'b010000 || op == 6'b010001) m_cf[who] = r[32];
      e.carry = m_cf[who];
    end
    return e;
  endfunction

  // Monitor and scoreboard.
  logic [N-1:0] mon_rdy, mon_acc;
  exp_t         mon_e;
  int           mon_w;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      q.delete();
      busy    = 1'b0;
      started = 1'b0;
      m_last  = N - 1;
      m_cf    = '0;
    end else begin
      mon_rdy = busy ? '0 : rr_pick(req_valid, m_last);
      chk("req_ready", 32'(req_ready), 32'(mon_rdy));
      if (rsp_valid != '0) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
        end else begin
          mon_e = q[0];
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << mon_e.who);
          if (!started) begin
            chk("latency", 32'(cyc - mon_e.acc), 32'd2);
            started = 1'b1;
          end
          chk("rsp_data", rsp_data, mon_e.data);
          chk("rsp_carry", 32'(rsp_carry), 32'(mon_e.carry));
          chk("rsp_z", 32'(rsp_z), 32'(mon_e.z));
          chk("rsp_n", 32'(rsp_n), 32'(mon_e.n));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          if (rsp_ready[mon_e.who]) begin
            void'(q.pop_front());
            busy    = 1'b0;
            started = 1'b0;
          end
        end
      end
      mon_acc = req_valid & req_ready;
      if (mon_acc != '0) begin
        mon_w = 0;
        for (int i = 0; i < N; i++) if (mon_acc[i]) mon_w = i;
        q.push_back(predict(mon_w, req_op[mon_w*6 +: 6], req_a[mon_w*32 +: 32],
                            req_b[mon_w*32 +: 32], req_use_c[mon_w]));
        m_last = mon_w;
        busy   = 1'b1;
      end
    end
  end

  task automatic set_cmd(input int who, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic uc);
    req_op[who*6 +: 6]   = op;
    req_a[who*32 +: 32]  = a;
    req_b[who*32 +: 32]  = b;
    req_use_c[who]       = uc;
    req_valid[who]       = 1'b1;
  endtask

  task automatic wait_accept(input int who);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(req_valid[who] && req_ready[who]) && t < 50);
    if (!(req_valid[who] && req_ready[who])) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    req_valid[who] = 1'b0;
  endtask

  task automatic issue(input int who, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic uc);
    set_cmd(who, op, a, b, uc);
    wait_accept(who);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (t >= 200) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [9];
    ops = '{6'b010000, 6'b010001, 6'b100000, 6'b100001, 6'b100010,
            6'b100011, 6'b110000, 6'b110001, 6'b110010};
    if ($urandom_range(0, 7) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 8)];
  endfunction

  logic [31:0]  sv_a, sv_b;
  logic [5:0]   sv_op;
  logic         sv_c;
  logic [N-1:0] acc;
  logic [31:0]  ra;
  int           prev, w, nacc, t;

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    req_use_c = '0; rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_carry, rsp_z, rsp_n, rsp_err}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op_c", {25'd0, alu_op, alu_c}, 32'd0);
    @(posedge clk);
    #1;

    // Carry chain on requester 0
    issue(0, T_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    drain();
    issue(0, T_ADD, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("alu_c_exec", 32'(alu_c), 32'd1);
    drain();

    // Borrow on requester 1 with requester 0 carrying a set flag
    issue(0, T_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    drain();
    issue(1, T_SUB, 32'd3, 32'd5, 1'b0);
    drain();
    issue(0, T_ADD, 32'd0, 32'd0, 1'b1);
    drain();

    // Illegal opcode leaves the ALU drive alone
    sv_a = alu_a; sv_b = alu_b; sv_op = alu_op; sv_c = alu_c;
    issue(0, 6'b000000, 32'd7, 32'd9, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("illegal_alu_a", alu_a, sv_a);
      chk("illegal_alu_b", alu_b, sv_b);
      chk("illegal_alu_op_c", {25'd0, alu_op, alu_c}, {25'd0, sv_op, sv_c});
    end
    drain();

    // Backpressure with a competing requester waiting
    rsp_ready = '0;
    issue(0, T_SHL, 32'd1, 32'd4, 1'b0);
    set_cmd(1, T_ADD, 32'd5, 32'd6, 1'b0);
    repeat (6) @(posedge clk);
    #1 rsp_ready = '1;
    wait_accept(1);
    drain();

    // Contention: both requesters keep valid asserted
    set_cmd(0, T_ADD, $urandom, $urandom, 1'b0);
    set_cmd(1, T_ADD, $urandom, $urandom, 1'b0);
    nacc = 0; prev = -1; t = 0;
    while (nacc < 8 && t < 100) begin
      @(negedge clk);
      t++;
      acc = req_valid & req_ready;
      if (acc != '0) begin
        w = acc[1] ? 1 : 0;
        if (prev >= 0) chk("grant_alternate", 32'(w), 32'(1 - prev));
        prev = w;
        nacc++;
        @(posedge clk);
        #1 set_cmd(w, T_ADD, $urandom, $urandom, 1'($urandom));
      end
    end
    if (nacc < 8) fail_now("contention_timeout");
    req_valid = '0;
    drain();

    // Random traffic with random response backpressure
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          ra = $urandom;
          set_cmd(i, rand_op(), ra, ($urandom_range(0, 1) == 1) ? ra : 32'($urandom_range(0, 40)),
                  1'($urandom));
        end
      end
      rsp_ready = N'($urandom);
    end
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = '1;
    drain();

    // Reset in EXEC drops the transaction and clears every carry flag
    issue(1, T_SUB, 32'd3, 32'd5, 1'b0);
    drain();
    issue(0, T_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rsp_valid_after_rst", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    set_cmd(0, T_ADD, 32'd0, 32'd0, 1'b1);
    set_cmd(1, T_ADD, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("first_win_after_rst", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_accept(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin controller that shares the single combinational 32-bit ALU between `N_REQ` requesters. Each requester uses a valid/ready command and response handshake. The block accepts one command at a time, drives registered operands and opcode into the ALU, and captures result and flags. It keeps a per-requester sticky carry/borrow flag so that multi-word add/sub chains can feed the ALU carry input. It sits between the instruction-issue logic and the ALU; the ALU is instantiated beside it, not inside.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, legal range 2..4.

Ports:
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `req_valid` input, `N_REQ` bits: command valid, one bit per requester.
- `req_ready` output, `N_REQ` bits: command accepted, one-hot or zero.
- `req_op` input, `6*N_REQ` bits: opcode; slice i belongs to requester i.
- `req_a`, `req_b` input, `32*N_REQ` bits each: operands.
- `req_use_c` input, `N_REQ` bits: 1 = feed the requester's stored carry flag into ALU `c`; 0 = `c` is 0.
- `rsp_valid` output, `N_REQ` bits: response valid, one-hot or zero.
- `rsp_ready` input, `N_REQ` bits: response consumed.
- `rsp_data` output, 32 bits: result.
- `rsp_carry`, `rsp_z`, `rsp_n`, `rsp_err` output, 1 bit each: carry/borrow, zero, negative, illegal opcode.
- `alu_a`, `alu_b` output, 32 bits each; `alu_op` output, 6 bits; `alu_c` output, 1 bit: registered drive to the ALU.
- `alu_ans1` input, 32 bits; `alu_ans2`, `alu_z`, `alu_n` input, 1 bit each: ALU outputs.

## Operation
- Legal opcodes:
  - ADD `010000`, SUB `010001`.
  - EQ `100000`, NE `100001`, LE `100010`, GT `100011`.
  - SHL `110000`, SHR `110001`, SRA `110010`.
  - Any other value is illegal.
- FSM states:
  - IDLE: `req_ready` asserted to the arbitration winner only. Handshake → EXEC.
  - EXEC: ALU inputs stable. Capture at the end of the cycle → RESP.
  - RESP: `rsp_valid[owner]` held. When `rsp_ready[owner]` is high → IDLE.
- Arbitration:
  - Round-robin. The search starts at `last+1` mod `N_REQ`.
  - `last` updates only on an accepted command. It resets to `N_REQ-1`, so requester 0 wins first.
- Carry flags `cf[i]`:
  - Updated only when requester i completes an ADD/SUB: `cf[i] <= alu_ans2`.
  - For SUB, the flag means borrow.
  - Other opcodes and illegal opcodes leave `cf[i]` unchanged. `rsp_carry` then reports the current `cf[i]`.
- Illegal opcode:
  - `alu_*` outputs are not updated.
  - The response carries `rsp_data=0`, `rsp_err=1`, `rsp_z=0`, `rsp_n=0`.
  - Latency is the same as a legal op.
- Legal responses:
  - `rsp_data`, `rsp_z` and `rsp_n` are taken from the ALU in EXEC.
  - `rsp_err=0`.
- Only the owner's `rsp_valid` bit is ever set. All `req_ready` bits are 0 outside IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready=0`, `rsp_valid=0`.
  - `rsp_data=0`, `rsp_carry`, `rsp_z`, `rsp_n` and `rsp_err` all 0.
  - `alu_a=0`, `alu_b=0`, `alu_op=0`, `alu_c=0`.
  - All `cf=0`; `last=N_REQ-1`.
- `req_ready` is combinational from `req_valid` and the state. It is asserted in the IDLE cycle T.
- `alu_*` outputs are registered at the end of T and are valid throughout T+1 (EXEC).
- Result registers load at the end of T+1. `rsp_valid` is high from T+2.
- Minimum turnaround is 3 cycles per command. A new command can be accepted the cycle after the response handshake.
- While `rsp_ready` is low, all `rsp_*` outputs are held stable and `alu_*` holds its value.
- Simultaneous valids: exactly one winner per IDLE cycle. Losers keep `req_valid` asserted and retry.
- `rsp_ready` is ignored in IDLE and EXEC.
- `rst` in any state: the next cycle is IDLE with reset values. The in-flight transaction is dropped with no response, and all `cf` are cleared.

## Structure
- Package `alu_ctrl_pkg`:
  - opcode localparams (`OP_ADD` … `OP_SRA`);
  - an `is_legal_op` function;
  - an `is_addsub` function;
  - state encoding `ST_IDLE`, `ST_EXEC`, `ST_RESP`.
- Sub-module `rr_arbiter`:
  - parameter `N`;
  - inputs `req[N]`, `last` index;
  - outputs one-hot `gnt` and `gnt_idx`;
  - purely combinational.
- Top-level: FSM, operand/result registers, and the `cf` array.

## Test plan
- Carry chain: req0 ADD a=`FFFFFFFF`, b=1, use_c=0 → data 0, carry 1, z=1, n=0. Then req0 ADD a=0, b=0, use_c=1 → data 1, carry 0, `alu_c`=1 during EXEC.
- Borrow: req1 SUB a=3, b=5 → data `FFFFFFFE`, carry 1, n=1, z=0. `cf[0]` is unaffected.
- Contention: both valid continuously with ADD → grants alternate 0, 1, 0, 1. Each response appears 2 cycles after its accept. Never two ready bits at once.
- Illegal op: req0 op `000000`, a=7 → data 0, err=1, `cf[0]` unchanged, `alu_*` unchanged. Latency is 2 cycles.
- Backpressure: SHL a=1, b=4, `rsp_ready` low for 5 cycles → data `00000010` held stable, `req_ready`=0 throughout, IDLE the cycle after `rsp_ready`.
- Reset mid-op: assert `rst` in EXEC after ADD a=`FFFFFFFF`, b=1 → no `rsp_valid`, `cf` all 0, requester 0 wins the next arbitration.
